// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the counter-run arbiter.
package cnt_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3
  } sched_state_t;

  localparam int NREQ_DEF    = 2;
  localparam int CW_DEF      = 4;
  localparam int TIMEOUT_DEF = 15;

  // A stop flag may be sticky, so only a low-to-high transition means completion.
  function automatic logic ok_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/cnt_run_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [PW-1:0] cand_s;

  // Scan from farthest to nearest so the nearest set request is written last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand_s = '0;
    for (int k = N; k >= 1; k--) begin
      cand_s = PW'((int'(ptr) + k) % N);
      any    = any | req[cand_s];
      idx    = req[cand_s] ? cand_s : idx;
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/cnt_run_arbiter.sv
// Shares one trigger/stop counter unit between NREQ requesters: round-robin grant,
// one trigger per run, rising-edge completion, timeout abort and result capture.
module cnt_run_arbiter
  import cnt_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic [CW-1:0]   result,
  output logic            busy,
  output logic            trg,
  input  logic [CW-1:0]   cnt_in,
  input  logic            ok_in
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t    state_r, state_s;
  logic [PW-1:0]   ptr_r, idx_r, pick_idx_s;
  logic [NREQ-1:0] pick_onehot_s, gnt_r, done_r;
  logic            pick_any_s, ok_q_r, comp_s, timeout_s;
  logic            err_r, busy_r, trg_r;
  logic [TW-1:0]   timer_r;
  logic [CW-1:0]   result_r;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .any    (pick_any_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  assign comp_s    = ok_rise(ok_in, ok_q_r);
  assign timeout_s = (timer_r == TW'(TIMEOUT - 1));

  // Next-state decode; completion takes priority over the timeout check.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_any_s) state_s = S_FIRE;
        else            state_s = S_IDLE;
      end
      S_FIRE: state_s = S_WAIT;
      S_WAIT: begin
        if (comp_s || timeout_s) state_s = S_DONE;
        else                     state_s = S_WAIT;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, edge-detect history and the registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      ok_q_r  <= 1'b0;
      trg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ok_q_r  <= ok_in;
      trg_r   <= (state_s == S_FIRE);
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_s == S_DONE) ? gnt_r : '0;
      err_r   <= (state_r == S_WAIT) && (state_s == S_DONE) && !comp_s;
    end
  end

  // Grant latch and round-robin pointer; the finished winner ranks last next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_r <= '0;
      idx_r <= '0;
      ptr_r <= PW'(NREQ - 1);
    end else if ((state_r == S_IDLE) && pick_any_s) begin
      gnt_r <= pick_onehot_s;
      idx_r <= pick_idx_s;
    end else if (state_r == S_DONE) begin
      gnt_r <= '0;
      ptr_r <= idx_r;
    end
  end

  // Wait timer (saturating, never wraps) and the captured count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r  <= '0;
      result_r <= '0;
    end else begin
      if (state_r == S_FIRE) begin
        timer_r <= '0;
      end else if ((state_r == S_WAIT) && (timer_r != TW'(TIMEOUT))) begin
        timer_r <= timer_r + TW'(1);
      end
      if ((state_r == S_WAIT) && comp_s) begin
        result_r <= cnt_in;
      end
    end
  end

  assign gnt    = gnt_r;
  assign done   = done_r;
  assign err    = err_r;
  assign result = result_r;
  assign busy   = busy_r;
  assign trg    = trg_r;

endmodule
